// File: rtl/leb128_decoder.sv
// Streaming LEB128 immediate decoder (WebAssembly i32/i64, signed and unsigned).
// One byte is consumed per in_valid/in_ready handshake. The result is extended
// to 64 bits and returned together with the encoded length.
// Optional build macro: LEB128_STRICT_EN rejects non-canonical unused bits in
// the byte at maximum length. Without it those bits are silently truncated.
module leb128_decoder #(
  parameter int OUT_W = 64,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_64,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_value,
  output logic [LEN_W-1:0] out_len,
  output logic             out_error,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT            state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             is64_q, is64_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             error_q, error_d;

  logic [6:0]       shiftAmt;
  logic [6:0]       fillShift;
  logic [LEN_W-1:0] nextCnt;
  logic [LEN_W-1:0] maxLen;
  logic             atMax;
  logic [OUT_W-1:0] merged;
  logic [OUT_W-1:0] fillMask;
  logic [OUT_W-1:0] filled;
  logic [OUT_W-1:0] finalValue;
  logic             canonicalOk;

  // Payload placement and sign fill; a fill shift of 64 or more yields an empty mask.
  assign shiftAmt   = 7'(cnt_q) * 7'd7;
  assign nextCnt    = cnt_q + LEN_W'(1);
  assign fillShift  = 7'(nextCnt) * 7'd7;
  assign maxLen     = is64_q ? LEN_W'(10) : LEN_W'(5);
  assign atMax      = (nextCnt == maxLen);
  assign merged     = acc_q | (OUT_W'(in_data[6:0]) << shiftAmt);
  assign fillMask   = ~((OUT_W'(1) << fillShift) - OUT_W'(1));
  assign filled     = (signed_q && in_data[6]) ? (merged | fillMask) : merged;
  assign finalValue = is64_q   ? filled :
                      signed_q ? {{(OUT_W-32){filled[31]}}, filled[31:0]} :
                                 {{(OUT_W-32){1'b0}}, filled[31:0]};

`ifdef LEB128_STRICT_EN
  // The terminating byte at maximum length may only carry bits that fit the immediate.
  always_comb begin
    canonicalOk = 1'b1;
    if (atMax) begin
      case ({is64_q, signed_q})
        2'b00:   canonicalOk = (in_data[6:4] == 3'b000);
        2'b01:   canonicalOk = (in_data[6:3] == 4'h0) || (in_data[6:3] == 4'hF);
        2'b10:   canonicalOk = (in_data[6:1] == 6'h00);
        default: canonicalOk = (in_data[6:0] == 7'h00) || (in_data[6:0] == 7'h7F);
      endcase
    end
  end
`else
  assign canonicalOk = 1'b1;
`endif

  // Next-state logic: latch the request, accumulate bytes, then hold the result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    is64_d   = is64_q;
    value_d  = value_q;
    len_d    = len_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          signed_d = is_signed;
          is64_d   = is_64;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = merged;
          cnt_d = nextCnt;
          if (!in_data[7]) begin
            state_d = DONE;
            len_d   = nextCnt;
            error_d = !canonicalOk;
            value_d = canonicalOk ? finalValue : '0;
          end else if (atMax) begin
            state_d = DONE;
            len_d   = nextCnt;
            error_d = 1'b1;
            value_d = '0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any partial decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      is64_q   <= 1'b0;
      value_q  <= '0;
      len_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      is64_q   <= is64_d;
      value_q  <= value_d;
      len_q    <= len_d;
      error_q  <= error_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_value = value_q;
  assign out_len   = len_q;
  assign out_error = error_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Self-checking bench for leb128_decoder: directed encodings, gaps, backpressure,
// overflow, reset mid-decode and randomly generated encodings.
// Expected results are queued when a request is issued and popped on out_valid.
module tb_leb128_decoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic        is_64;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_error;
  logic        out_ready;

  typedef struct packed {
    logic [63:0] value;
    logic [3:0]  len;
    logic        err;
  } expT;

  expT sbQ[$];
  int  errors = 0;
  int  checks = 0;
  int  cycleCount = 0;
  int  startCycle = 0;
  int  consumed = 0;

  leb128_decoder #(.OUT_W(64), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .is_64     (is_64),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_len   (out_len),
    .out_error (out_error),
    .out_ready (out_ready)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so latency can be measured from the start request.
  always @(posedge clk) cycleCount++;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic expT mkExp(input logic [63:0] v, input logic [3:0] l, input logic e);
    expT r;
    r.value = v;
    r.len   = l;
    r.err   = e;
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference LEB128 encoder used to build random stimulus from a known value.
  task automatic encodeLeb(input logic [63:0] v, input bit sgn, output logic [7:0] seq [10], output int n);
    logic [63:0] r;
    logic [7:0]  b;
    bit          more;
    r    = v;
    n    = 0;
    more = 1'b1;
    seq  = '{default: 8'h00};
    while (more && n < 10) begin
      b = {1'b0, r[6:0]};
      if (sgn) begin
        r    = $signed(r) >>> 7;
        more = !((r == 64'd0 && !b[6]) || (r == '1 && b[6]));
      end else begin
        r    = r >> 7;
        more = (r != 64'd0);
      end
      if (more) b[7] = 1'b1;
      seq[n] = b;
      n++;
    end
  endtask

  // Issue a request, queue its expectation, then feed bytes (gap idle cycles after the first).
  task automatic applyStimulus(input bit sgn, input bit w64, input logic [7:0] seq [10],
                               input int n, input int gap, input expT exp);
    @(negedge clk);
    start      = 1'b1;
    is_signed  = sgn;
    is_64      = w64;
    startCycle = cycleCount;
    sbQ.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    checkVal("inReadyAfterStart", in_ready, 1);
    consumed = 0;
    for (int k = 0; k < n; k++) begin
      if (out_valid) break;
      in_valid = 1'b1;
      in_data  = seq[k];
      @(negedge clk);
      in_valid = 1'b0;
      consumed++;
      if (k == 0) repeat (gap) @(negedge clk);
    end
    in_data = 8'h00;
  endtask

  // Wait for the result, compare it with the queued expectation, hold, then release.
  task automatic checkOutput(input string tag, input int expLatency, input int hold, input bit startWithReady);
    expT exp;
    int  waitCount;
    waitCount = 0;
    while (!out_valid && waitCount < 40) begin
      @(negedge clk);
      waitCount++;
    end
    checkVal({tag, "_outValid"}, out_valid, 1);
    if (sbQ.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
      exp = mkExp(64'd0, 4'd0, 1'b0);
    end else begin
      exp = sbQ.pop_front();
    end
    checkVal({tag, "_value"}, out_value, exp.value);
    checkVal({tag, "_len"}, out_len, exp.len);
    checkVal({tag, "_error"}, out_error, exp.err);
    if (expLatency >= 0) checkVal({tag, "_latency"}, cycleCount - startCycle, expLatency);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkVal({tag, "_holdValid"}, out_valid, 1);
      checkVal({tag, "_holdValue"}, out_value, exp.value);
      checkVal({tag, "_holdLen"}, out_len, exp.len);
    end
    out_ready = 1'b1;
    start     = startWithReady;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    checkVal({tag, "_idleValid"}, out_valid, 0);
    checkVal({tag, "_idleInReady"}, in_ready, 0);
  endtask

  // Directed sequence followed by random round-trip encodings.
  initial begin
    logic [7:0]  seq [10];
    logic [63:0] v;
    logic [31:0] w;
    int          n;

    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    is_64     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #10;
    checkVal("rstInReady", in_ready, 0);
    checkVal("rstOutValid", out_valid, 0);
    checkVal("rstOutValue", out_value, 0);
    checkVal("rstOutLen", out_len, 0);
    checkVal("rstOutError", out_error, 0);
    @(negedge clk);
    reset = 1'b1;

    // Unsigned 32-bit E5 8E 26, no gaps.
    seq = '{default: 8'h00};
    seq[0] = 8'hE5; seq[1] = 8'h8E; seq[2] = 8'h26;
    applyStimulus(1'b0, 1'b0, seq, 3, 0, mkExp(64'h0000_0000_0009_8765, 4'd3, 1'b0));
    checkOutput("u32Basic", 4, 0, 1'b0);

    // Signed 64-bit C0 BB 78.
    seq = '{default: 8'h00};
    seq[0] = 8'hC0; seq[1] = 8'hBB; seq[2] = 8'h78;
    applyStimulus(1'b1, 1'b1, seq, 3, 0, mkExp(64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0));
    checkOutput("s64Neg", 4, 0, 1'b0);

    // Signed 32-bit 7F, with start raised during the release handshake.
    seq = '{default: 8'h00};
    seq[0] = 8'h7F;
    applyStimulus(1'b1, 1'b0, seq, 1, 0, mkExp(64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0));
    checkOutput("s32MinusOne", 2, 0, 1'b1);

    // Unsigned 32-bit overflow: 80 x5 then 00; the 6th byte must not be taken.
    seq = '{default: 8'h00};
    for (int i = 0; i < 5; i++) seq[i] = 8'h80;
    applyStimulus(1'b0, 1'b0, seq, 6, 0, mkExp(64'd0, 4'd5, 1'b1));
    checkVal("ovfConsumed", consumed, 5);
    checkVal("ovfInReady", in_ready, 0);
    checkOutput("u32Overflow", -1, 0, 1'b0);

    // Unsigned 32-bit FF FF FF FF 1F: unused bits set in the last byte.
    seq = '{default: 8'h00};
    for (int i = 0; i < 4; i++) seq[i] = 8'hFF;
    seq[4] = 8'h1F;
`ifdef LEB128_STRICT_EN
    applyStimulus(1'b0, 1'b0, seq, 5, 0, mkExp(64'd0, 4'd5, 1'b1));
`else
    applyStimulus(1'b0, 1'b0, seq, 5, 0, mkExp(64'h0000_0000_FFFF_FFFF, 4'd5, 1'b0));
`endif
    checkOutput("u32MaxLen", 6, 0, 1'b0);

    // Input gap of two cycles and three cycles of output backpressure.
    seq = '{default: 8'h00};
    seq[0] = 8'hE5; seq[1] = 8'h8E; seq[2] = 8'h26;
    applyStimulus(1'b0, 1'b0, seq, 3, 2, mkExp(64'h0000_0000_0009_8765, 4'd3, 1'b0));
    checkOutput("u32GapHold", 6, 3, 1'b0);

    // Reset after the first byte, then a fresh single-byte decode.
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    is_64     = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hE5;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    checkVal("midRstInReady", in_ready, 0);
    checkVal("midRstOutValid", out_valid, 0);
    checkVal("midRstOutLen", out_len, 0);
    @(negedge clk);
    reset = 1'b1;
    seq = '{default: 8'h00};
    seq[0] = 8'h2A;
    applyStimulus(1'b0, 1'b0, seq, 1, 0, mkExp(64'd42, 4'd1, 1'b0));
    checkOutput("afterReset", 2, 0, 1'b0);

    // Random round trips through the reference encoder.
    for (int i = 0; i < 9; i++) begin
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      case (i % 3)
        0: begin
          encodeLeb(v, 1'b0, seq, n);
          applyStimulus(1'b0, 1'b1, seq, n, 0, mkExp(v, 4'(n), 1'b0));
        end
        1: begin
          if (i % 2 == 1) v = ~v;
          encodeLeb(v, 1'b1, seq, n);
          applyStimulus(1'b1, 1'b1, seq, n, 0, mkExp(v, 4'(n), 1'b0));
        end
        default: begin
          w = $urandom >> $urandom_range(0, 31);
          if (i % 2 == 1) w = ~w;
          v = {{32{w[31]}}, w};
          encodeLeb(v, 1'b1, seq, n);
          applyStimulus(1'b1, 1'b0, seq, n, 0, mkExp(v, 4'(n), 1'b0));
        end
      endcase
      checkOutput("random", n + 1, 0, 1'b0);
    end

    checkVal("scoreboardEmpty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leb128_decoder.md
# leb128_decoder

Streaming LEB128 decoder between the instruction-fetch byte stream from `genrom` and the `cpu` decode stage. Decodes one unsigned or signed immediate (i32/i64 width, WebAssembly encoding) per request, consuming one byte per accepted handshake. It returns the value sign- or zero-extended to 64 bits, with the encoded length, so the CPU can advance its program counter.

## Interface
Parameters:
- `OUT_W`, 64: output value width; fixed at 64, never overridden.
- `LEN_W`, 4: width of `out_len`; must hold 10.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request a decode; sampled only in IDLE.
- `is_signed`  in  1  signed LEB128 when 1; sampled with `start`.
- `is_64`  in  1  64-bit immediate when 1, else 32-bit; sampled with `start`.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_data`  in  8  encoded byte; bit 7 is continuation, bits 6:0 payload.
- `in_ready`  out  1  decoder accepts a byte this cycle.
- `out_valid`  out  1  result available.
- `out_value`  out  64  decoded value, extended to 64 bits.
- `out_len`  out  4  bytes consumed (1..10).
- `out_error`  out  1  malformed encoding; qualifies `out_valid`.
- `out_ready`  in  1  consumer takes result.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: `start`=1 latches `is_signed`/`is_64`, clears accumulator, count and shift, then goes to ACCUM. `start` outside IDLE is ignored.
- ACCUM: `in_ready`=1. A byte is accepted when `in_valid && in_ready`:
  - OR `in_data[6:0] << 7*count` into the accumulator, truncated to 64 bits.
  - Increment count.
- Last byte (bit 7 = 0):
  - Signed with `in_data[6]`=1: fill all bits at and above `7*(count+1)` with 1.
  - 32-bit mode: truncate to bits 31:0, then sign-extend (signed) or zero-extend (unsigned) to 64.
  - Go to DONE with `out_error`=0.
- Overflow: if the accepted byte has bit 7 = 1 and count reaches the maximum (5 for 32-bit, 10 for 64-bit), go to DONE with `out_error`=1, `out_value`=0, `out_len`=max.
- DONE: `out_valid`=1, `in_ready`=0; all outputs hold stable until `out_ready`=1. The cycle after `out_ready`, the block is in IDLE with `out_valid`=0.
- `in_valid` gaps in ACCUM stall the decode with no state change.
- Reset mid-decode: immediate return to IDLE; the partial value is discarded.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_value`=0, `out_len`=0, `out_error`=0; state IDLE.
- `start` at edge T → ACCUM, `in_ready`=1 from T+1.
- Final byte accepted at edge N → `out_valid`=1 from N+1. Best case for an n-byte encoding with no gaps: n+1 cycles from `start`.
- `out_ready` is only honoured while `out_valid`=1. If `out_ready` is high when DONE is entered, `out_valid` still lasts exactly one cycle.
- `start` asserted in the same cycle as the `out_ready` handshake is ignored; the next request must be issued in IDLE.

## Configuration
- `LEB128_STRICT_EN` defined: the byte at maximum length must have canonical unused bits, else `out_error`=1 and `out_value`=0.
  - 32-bit unsigned: bits 6:4 = 0.
  - 32-bit signed: bits 6:3 all equal.
  - 64-bit unsigned: bits 6:1 = 0.
  - 64-bit signed: byte is 0x00 or 0x7F.
- Undefined: unused bits are silently truncated and only the overflow error exists. Logic and timing are otherwise identical.

## Test plan
- Unsigned 32-bit, bytes E5 8E 26, no gaps → `out_value`=0x0000_0000_0009_8765 (624485), `out_len`=3, `out_error`=0, `out_valid` 4 cycles after `start`.
- Signed 64-bit, bytes C0 BB 78 → `out_value`=0xFFFF_FFFF_FFFE_1DC0 (−123456), `out_len`=3. Signed 32-bit, byte 7F → 0xFFFF_FFFF_FFFF_FFFF, `out_len`=1.
- Unsigned 32-bit, bytes 80 80 80 80 80 00 → `out_error`=1 after the 5th byte, `out_len`=5, `in_ready`=0; 6th byte not consumed.
- Unsigned 32-bit, bytes FF FF FF FF 1F:
  - With `LEB128_STRICT_EN` → `out_error`=1, `out_value`=0.
  - Without it → `out_value`=0x0000_0000_FFFF_FFFF, `out_error`=0, `out_len`=5.
- Backpressure and gaps, bytes E5 8E 26:
  - `in_valid` low 2 cycles between bytes → same result, latency +2.
  - `out_ready` held low 3 cycles → outputs stable; IDLE one cycle after `out_ready`.
- `reset` pulsed low after the 1st byte of E5 8E 26 → `in_ready`, `out_valid` = 0 immediately. New `start` with single byte 2A → `out_value`=42, `out_len`=1.
